// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared UART definitions: receiver state encoding, default payload width
//   and the clocks-per-bit helper used to derive bit timing from clock/baud.
package uart_pkg;

  // Frame width when the instantiating block does not override it.
  localparam int DEFAULT_PAYLOAD_BITS = 8;

  // Receiver FSM state, 3-bit encoding.
  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_t;

  // Whole clocks per serial bit; integer division truncates (434 at 50 MHz / 115200).
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync
//   Two-flop synchronizer for asynchronous inputs. Resets to all ones so an
//   idle-high serial line does not look like a start bit coming out of reset.
// Ports
//   clk  in  1      system clock
//   rst  in  1      synchronous active-low reset
//   d    in  WIDTH  asynchronous inputs
//   q    out WIDTH  inputs delayed two clocks, in the clk domain
module uart_rx_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_byte_receiver.sv
// uart_byte_receiver
//   UART receiver, 8N1 by default, LSB first. The line is synchronized, the
//   start bit is qualified at its middle (rejecting short glitches) and each
//   subsequent bit is sampled one bit period later, i.e. at mid-bit.
// Ports
//   clk               in   1             system clock
//   rst               in   1             synchronous active-low reset
//   uart_rxd          in   1             asynchronous serial line, idle high
//   uart_rx_data      out  PAYLOAD_BITS  last correctly framed byte (held)
//   uart_rx_valid     out  1             one-cycle pulse, uart_rx_data updated
//   uart_rx_frame_err out  1             one-cycle pulse, stop bit sampled low
//   uart_rx_busy      out  1             frame in progress (incl. break wait)
module uart_byte_receiver
  import uart_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BAUD         = 115_200,
  parameter int PAYLOAD_BITS = DEFAULT_PAYLOAD_BITS,
  parameter int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    uart_rxd,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_rx_valid,
  output logic                    uart_rx_frame_err,
  output logic                    uart_rx_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(PAYLOAD_BITS + 1);

  // Start bit is checked half a bit in; every later sample is a full bit on.
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(PAYLOAD_BITS - 1);

  logic                    rxd_s;
  rx_state_t               state;
  logic [CNT_W-1:0]        clk_cnt;
  logic [IDX_W-1:0]        bit_idx;
  logic [PAYLOAD_BITS-1:0] shift_reg;
  logic [PAYLOAD_BITS-1:0] shift_next;

  uart_rx_sync #(.WIDTH(1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (uart_rxd),
    .q   (rxd_s)
  );

  // New bits enter at the MSB so the first (LSB) bit ends up at bit 0
  // after PAYLOAD_BITS shifts.
  always_comb begin
    shift_next                 = shift_reg >> 1;
    shift_next[PAYLOAD_BITS-1] = rxd_s;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state             <= RX_IDLE;
      clk_cnt           <= '0;
      bit_idx           <= '0;
      shift_reg         <= '0;
      uart_rx_data      <= '0;
      uart_rx_valid     <= 1'b0;
      uart_rx_frame_err <= 1'b0;
      uart_rx_busy      <= 1'b0;
    end else begin
      uart_rx_valid     <= 1'b0;
      uart_rx_frame_err <= 1'b0;
      unique case (state)
        RX_IDLE: begin
          clk_cnt <= '0;
          if (!rxd_s) begin
            state        <= RX_START;
            uart_rx_busy <= 1'b1;
          end
        end

        RX_START: begin
          if (clk_cnt == HALF_LAST) begin
            clk_cnt <= '0;
            if (!rxd_s) begin
              state   <= RX_DATA;
              bit_idx <= '0;
            end else begin
              // Line already back high at mid start bit: glitch, drop it.
              state        <= RX_IDLE;
              uart_rx_busy <= 1'b0;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

        RX_DATA: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt   <= '0;
            shift_reg <= shift_next;
            bit_idx   <= bit_idx + IDX_W'(1);
            if (bit_idx == IDX_LAST) state <= RX_STOP;
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

        RX_STOP: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            if (rxd_s) begin
              uart_rx_data  <= shift_reg;
              uart_rx_valid <= 1'b1;
              state         <= RX_IDLE;
              uart_rx_busy  <= 1'b0;
            end else begin
              uart_rx_frame_err <= 1'b1;
              state             <= RX_BREAK;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

        RX_BREAK: begin
          // Hold off until the line returns high so a held-low line
          // is not mistaken for a stream of start bits.
          if (rxd_s) begin
            state        <= RX_IDLE;
            uart_rx_busy <= 1'b0;
          end
        end

        default: begin
          state        <= RX_IDLE;
          clk_cnt      <= '0;
          uart_rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_byte_receiver.sv
// tb_uart_byte_receiver
//   Scoreboard bench: expected bytes are queued as frames are sent and popped
//   when the receiver pulses valid. A second instance runs at 8 clk/bit for
//   the baud-skew case.
module tb_uart_byte_receiver;

  localparam int CPB = 434;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rxd = 1'b1;
  logic       rxd8 = 1'b1;
  logic [7:0] data, data8;
  logic       valid, ferr, busy;
  logic       valid8, ferr8, busy8;

  int errors = 0;
  int checks = 0;
  int valid_cnt = 0, ferr_cnt = 0;
  int valid8_cnt = 0, ferr8_cnt = 0;
  logic busy_pend = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] exp8_q[$];

  always #10 clk = ~clk;

  uart_byte_receiver u_dut (
    .clk               (clk),
    .rst               (rst),
    .uart_rxd          (rxd),
    .uart_rx_data      (data),
    .uart_rx_valid     (valid),
    .uart_rx_frame_err (ferr),
    .uart_rx_busy      (busy)
  );

  uart_byte_receiver #(.CLK_HZ(1_000_000), .BAUD(125_000)) u_dut8 (
    .clk               (clk),
    .rst               (rst),
    .uart_rxd          (rxd8),
    .uart_rx_data      (data8),
    .uart_rx_valid     (valid8),
    .uart_rx_frame_err (ferr8),
    .uart_rx_busy      (busy8)
  );

  // Scoreboard for the default-rate instance.
  always @(negedge clk) begin
    logic [7:0] e;
    if (busy_pend) begin
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL busy_after_valid: got %0b want 0", busy);
      end
    end
    busy_pend = valid;
    if (valid || ferr) begin
      checks++;
      if (valid && ferr) begin
        errors++;
        $display("FAIL valid_and_err: both high together");
      end
    end
    if (ferr) ferr_cnt++;
    if (valid) begin
      valid_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got data %02h, none expected", data);
      end else begin
        e = exp_q.pop_front();
        if (data !== e) begin
          errors++;
          $display("FAIL rx_data: got %02h want %02h", data, e);
        end
      end
    end
  end

  // Scoreboard for the 8 clk/bit instance.
  always @(negedge clk) begin
    logic [7:0] e;
    if (ferr8) ferr8_cnt++;
    if (valid8) begin
      valid8_cnt++;
      checks++;
      if (exp8_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid8: got data %02h", data8);
      end else begin
        e = exp8_q.pop_front();
        if (data8 !== e) begin
          errors++;
          $display("FAIL rx_data8: got %02h want %02h", data8, e);
        end
      end
    end
  end

  // Drive one frame at the default rate; stop_bit lets a framing error be forced.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = frame[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = 1'b1;
  endtask

  // Drive one 8N1 frame to the 8 clk/bit instance; per100 is the bit period in 1/100 clk.
  task automatic send_skew(input logic [7:0] b, input int per100);
    logic [9:0] frame;
    int         idx;
    frame = {1'b1, b, 1'b0};
    for (int t = 0; t < 200; t++) begin
      idx  = (t * 100) / per100;
      rxd8 = (idx < 10) ? frame[idx] : 1'b1;
      @(negedge clk);
    end
    rxd8 = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0; rxd = 1'b1; rxd8 = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %02h want 00", data); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", valid); end
    checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %0b want 0", ferr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy8: got %0b want 0", busy8); end
    rst = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %0b want 0", busy); end
  endtask

  task automatic test_single_byte;
    int v0, f0;
    v0 = valid_cnt; f0 = ferr_cnt;
    exp_q.push_back(8'h5A);
    send_byte(8'h5A, 1'b1);
    repeat (CPB) @(negedge clk);
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL single_valid_count: got %0d want 1", valid_cnt - v0); end
    checks++; if (ferr_cnt !== f0) begin errors++; $display("FAIL single_ferr_count: got %0d want %0d", ferr_cnt, f0); end
    checks++; if (data !== 8'h5A) begin errors++; $display("FAIL single_data_hold: got %02h want 5a", data); end
  endtask

  task automatic test_back_to_back;
    int v0;
    v0 = valid_cnt;
    exp_q.push_back(8'h00);
    send_byte(8'h00, 1'b1);
    exp_q.push_back(8'hFF);
    send_byte(8'hFF, 1'b1);
    repeat (CPB) @(negedge clk);
    checks++; if (valid_cnt - v0 !== 2) begin errors++; $display("FAIL b2b_valid_count: got %0d want 2", valid_cnt - v0); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL b2b_queue_left: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_glitch;
    int v0, f0, busy_cyc;
    v0 = valid_cnt; f0 = ferr_cnt; busy_cyc = 0;
    rxd = 1'b0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (i == 129) rxd = 1'b1;
      if (busy) busy_cyc++;
    end
    checks++; if (busy_cyc < 214 || busy_cyc > 220) begin errors++; $display("FAIL glitch_busy_len: got %0d want 214..220", busy_cyc); end
    checks++; if (valid_cnt !== v0 || ferr_cnt !== f0) begin errors++; $display("FAIL glitch_pulses: got valid+%0d err+%0d want 0 0", valid_cnt - v0, ferr_cnt - f0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_idle: got busy %0b want 0", busy); end
  endtask

  task automatic test_frame_error;
    int v0, f0;
    v0 = valid_cnt; f0 = ferr_cnt;
    send_byte(8'hA5, 1'b0);
    rxd = 1'b0; // hold the break past the forced-low stop bit
    checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_count: got %0d want 1", ferr_cnt - f0); end
    checks++; if (data !== 8'hFF) begin errors++; $display("FAIL ferr_data_hold: got %02h want ff", data); end
    repeat (5 * CPB) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL break_busy: got %0b want 1", busy); end
    checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL break_no_retrigger: got %0d err pulses want 1", ferr_cnt - f0); end
    rxd = 1'b1;
    repeat (CPB) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL break_release: got busy %0b want 0", busy); end
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, 1'b1);
    repeat (CPB) @(negedge clk);
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL ferr_valid_count: got %0d want 1", valid_cnt - v0); end
  endtask

  task automatic test_mid_frame_reset;
    int v0;
    logic [9:0] frame;
    v0 = valid_cnt;
    frame = {1'b1, 8'h81, 1'b0};
    // start bit and data bits 0..3, then half of bit 4
    for (int i = 0; i < 5; i++) begin
      rxd = frame[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = frame[5];
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b0; rxd = 1'b1;
    @(negedge clk);
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL rst_mid_data: got %02h want 00", data); end
    checks++; if (valid !== 1'b0 || ferr !== 1'b0) begin errors++; $display("FAIL rst_mid_pulses: got v%0b e%0b want 0 0", valid, ferr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %0b want 0", busy); end
    rst = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    checks++; if (valid_cnt !== v0) begin errors++; $display("FAIL rst_mid_no_valid: got %0d pulses want 0", valid_cnt - v0); end
    exp_q.push_back(8'h42);
    send_byte(8'h42, 1'b1);
    repeat (CPB) @(negedge clk);
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL rst_next_valid: got %0d want 1", valid_cnt - v0); end
  endtask

  task automatic test_baud_skew;
    int v0;
    v0 = valid8_cnt;
    exp8_q.push_back(8'h96);
    send_skew(8'h96, 824);   // 3% slow
    exp8_q.push_back(8'h96);
    send_skew(8'h96, 776);   // 3% fast
    repeat (20) @(negedge clk);
    checks++; if (valid8_cnt - v0 !== 2) begin errors++; $display("FAIL skew_valid_count: got %0d want 2", valid8_cnt - v0); end
    checks++; if (ferr8_cnt !== 0) begin errors++; $display("FAIL skew_ferr: got %0d want 0", ferr8_cnt); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_mid_frame_reset();
    test_baud_skew();
    checks++;
    if (exp_q.size() !== 0 || exp8_q.size() !== 0) begin
      errors++;
      $display("FAIL missing_frames: got %0d/%0d pending want 0/0", exp_q.size(), exp8_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
